// File: rtl/regfile_multiport.sv
// Multi-read-port register file with registered reads, write forwarding, sub-word extension
// and a post-reset clear sequencer. Define REGFILE_DEBUG_PORT_EN to add the DbgAddr/DbgData view.
module regfile_multiport #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [2:0]                 WrMode,
   input  logic [ADDR_W-1:0]          WrAddr,
   input  logic [DATA_W-1:0]          WrData,
   input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
   output logic [NUM_RD*DATA_W-1:0]   RdData,
`ifdef REGFILE_DEBUG_PORT_EN
   input  logic [ADDR_W-1:0]          DbgAddr,
   output logic [DATA_W-1:0]          DbgData,
`endif
   output logic                       Ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic StClear = 1'b0;
   localparam logic StRun   = 1'b1;

   logic                     stateQ, stateD;
   logic [ADDR_W-1:0]        clrPtrQ, clrPtrD;
   logic [NUM_RD*DATA_W-1:0] rdDataQ, rdDataD;
   logic [DATA_W-1:0]        extData;
   logic                     wrActive, wrEn;
   logic [ADDR_W-1:0]        rdA;
   logic [DATA_W-1:0]        mem [DEPTH];

   always_comb begin
      extData = '0;
      case (WrMode)
         3'd1:    extData = WrData;
         3'd2:    extData = {{(DATA_W-8){WrData[7]}}, WrData[7:0]};
         3'd3:    extData = {{(DATA_W-16){WrData[15]}}, WrData[15:0]};
         3'd4:    extData = {{(DATA_W-8){1'b0}}, WrData[7:0]};
         3'd5:    extData = {{(DATA_W-16){1'b0}}, WrData[15:0]};
         default: extData = '0;
      endcase
   end

   // Dropped writes (CLEAR, hardwired zero) must not forward either.
   assign wrActive = (WrMode >= 3'd1) && (WrMode <= 3'd5);
   assign wrEn     = (stateQ == StRun) && wrActive && !((ZERO_REG != 0) && (WrAddr == '0));

   always_comb begin
      stateD  = stateQ;
      clrPtrD = clrPtrQ;
      if (stateQ == StClear) begin
         clrPtrD = clrPtrQ + 1'b1;
         if (clrPtrQ == '1) stateD = StRun;
      end
   end

   always_comb begin
      rdDataD = '0;
      rdA     = '0;
      if (stateQ == StRun) begin
         for (int i = 0; i < NUM_RD; i++) begin
            rdA = RdAddr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (rdA == '0)) begin
               rdDataD[i*DATA_W +: DATA_W] = '0;
            end else if (wrEn && (WrAddr == rdA)) begin
               rdDataD[i*DATA_W +: DATA_W] = extData;
            end else begin
               rdDataD[i*DATA_W +: DATA_W] = mem[rdA];
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stateQ  <= StClear;
         clrPtrQ <= '0;
         rdDataQ <= '0;
      end else begin
         stateQ  <= stateD;
         clrPtrQ <= clrPtrD;
         rdDataQ <= rdDataD;
      end
   end

   // Storage has no reset; the sequencer zeroes it one entry per cycle.
   always_ff @(posedge Clk) begin
      if (stateQ == StClear) begin
         mem[clrPtrQ] <= '0;
      end else if (wrEn) begin
         mem[WrAddr] <= extData;
      end
   end

`ifdef REGFILE_DEBUG_PORT_EN
   assign DbgData = ((ZERO_REG != 0) && (DbgAddr == '0)) ? '0 : mem[DbgAddr];
`endif

   assign RdData = rdDataQ;
   assign Ready  = (stateQ == StRun);

endmodule
